// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an idle-high serial line
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // Reset to 1 so a freshly reset receiver sees an idle line, not a start bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with optional parity and break handling
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEFAULT,
    parameter int SB_TICK    = SB_TICK_DEFAULT,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_parity_err
);

    localparam int NW = $clog2(DBIT);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [4:0]    S_MID  = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0]    S_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
    localparam logic          HAS_PARITY = (PARITY_EN != 0);
    localparam logic          ODD_INV    = (PARITY_ODD != 0);

    logic rx_s;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    rx_state_t       state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            pbit_q, pbit_d;
    logic            stop_q, stop_d;
    logic            armed_q, armed_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        pbit_d  = pbit_q;
        stop_d  = stop_q;
        armed_d = armed_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                    s_d     = 5'd0;
                end
            end
            ST_START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = 5'd0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                            par_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) begin
                        b_d   = {rx_s, b_q[DBIT-1:1]};
                        s_d   = 5'd0;
                        par_d = par_q ^ rx_s;
                        if (n_q == N_LAST) begin
                            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) begin
                        pbit_d  = rx_s;
                        s_d     = 5'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_STOP) begin
                        stop_d  = rx_s;
                        s_d     = 5'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        // A low stop bit means a break may be in progress: wait for idle first.
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 5'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            s_q            <= 5'd0;
            n_q            <= '0;
            b_q            <= '0;
            par_q          <= 1'b0;
            pbit_q         <= 1'b0;
            stop_q         <= 1'b1;
            armed_q        <= 1'b1;
            done_q         <= 1'b0;
            o_data         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            o_parity_err   <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            n_q            <= n_d;
            b_q            <= b_d;
            par_q          <= par_d;
            pbit_q         <= pbit_d;
            stop_q         <= stop_d;
            armed_q        <= armed_d;
            done_q         <= done_d;
            o_rx_done_tick <= done_q;
            // Shift register cannot move until the next frame's data state, so it is stable here.
            if (done_q) begin
                o_data       <= b_q;
                o_frame_err  <= ~stop_q;
                o_parity_err <= HAS_PARITY ? (par_q ^ pbit_q ^ ODD_INV) : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic line = 1'b1;
    int   sel = 0;
    int   tcnt = 0;

    logic rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b;
    logic [4:0] data_c;
    logic done_a, done_b, done_c;
    logic fe_a, fe_b, fe_c;
    logic pe_a, pe_b, pe_c;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    uart_rx dut_a (
        .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_a),
        .o_data(data_a), .o_rx_done_tick(done_a), .o_frame_err(fe_a), .o_parity_err(pe_a)
    );

    uart_rx #(.DBIT(8), .SB_TICK(24), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_b),
        .o_data(data_b), .o_rx_done_tick(done_b), .o_frame_err(fe_b), .o_parity_err(pe_b)
    );

    uart_rx #(.DBIT(5), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_c),
        .o_data(data_c), .o_rx_done_tick(done_c), .o_frame_err(fe_c), .o_parity_err(pe_c)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            tick = ((tcnt % 4) == 0);
        end
    end

    rec_t qa[$], qb[$], qc[$];
    int   n_tests = 0, n_fail = 0;
    int   viol = 0, done_total = 0, exp_total = 0;
    logic [9:0] prev_a = '0, prev_b = '0;
    logic [6:0] prev_c = '0;
    logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0;

    always @(negedge clk) begin
        if (done_a) begin qa.push_back({data_a, fe_a, pe_a}); done_total++; end
        if (done_b) begin qb.push_back({data_b, fe_b, pe_b}); done_total++; end
        if (done_c) begin qc.push_back({3'b000, data_c, fe_c, pe_c}); done_total++; end
        if (!rst) begin
            if (!done_a && {data_a, fe_a, pe_a} != prev_a) viol++;
            if (!done_b && {data_b, fe_b, pe_b} != prev_b) viol++;
            if (!done_c && {data_c, fe_c, pe_c} != prev_c) viol++;
            if ((done_a && pd_a) || (done_b && pd_b) || (done_c && pd_c)) viol++;
        end
        prev_a = {data_a, fe_a, pe_a};
        prev_b = {data_b, fe_b, pe_b};
        prev_c = {data_c, fe_c, pe_c};
        pd_a = done_a; pd_b = done_b; pd_c = done_c;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v, input int k);
        @(negedge clk);
        line = v;
        wait_ticks(k);
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input logic pbit, input logic stopv);
        int nb, sb;
        logic pen;
        nb  = (s == 2) ? 5 : 8;
        pen = (s != 0);
        sb  = (s == 0) ? 16 : ((s == 1) ? 24 : 32);
        sel = s;
        send_bit(1'b0, 16);
        for (int i = 0; i < nb; i++) send_bit(d[i], 16);
        if (pen) send_bit(pbit, 16);
        send_bit(stopv, sb);
    endtask

    // Reference: data masked to the word width, frame error = low stop,
    // parity error = XOR of data and parity bit, inverted for odd parity.
    function automatic rec_t model(input int s, input logic [7:0] d, input logic pbit, input logic stopv);
        rec_t r;
        logic [7:0] dm;
        dm   = (s == 2) ? (d & 8'h1F) : d;
        r.d  = dm;
        r.fe = ~stopv;
        r.pe = (s == 0) ? 1'b0 : ((^dm) ^ pbit ^ (s == 2));
        return r;
    endfunction

    function automatic int qsize(input int s);
        if (s == 0) return qa.size();
        if (s == 1) return qb.size();
        return qc.size();
    endfunction

    task automatic qpop(input int s, output rec_t r);
        if (s == 0) r = qa.pop_front();
        else if (s == 1) r = qb.pop_front();
        else r = qc.pop_front();
    endtask

    task automatic expect_frame(input string tag, input int s, input rec_t e);
        rec_t got;
        int   t;
        logic ok;
        t  = 0;
        ok = (qsize(s) > 0);
        while (!ok && t < 600) begin
            @(negedge clk);
            t++;
            ok = (qsize(s) > 0);
        end
        exp_total++;
        check({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            qpop(s, got);
            check({tag, "_data"}, 32'(got.d), 32'(e.d));
            check({tag, "_ferr"}, 32'(got.fe), 32'(e.fe));
            check({tag, "_perr"}, 32'(got.pe), 32'(e.pe));
        end
    endtask

    initial begin
        logic [7:0] d;
        logic pb, sv;
        int s, gap;

        repeat (5) @(negedge clk);
        check("reset_a", {22'd0, data_a, fe_a, pe_a}, 32'd0);
        check("reset_done", {29'd0, done_a, done_b, done_c}, 32'd0);
        rst = 1'b0;
        send_bit(1'b1, 20);

        send_frame(0, 8'h55, 1'b0, 1'b1);
        expect_frame("f55", 0, model(0, 8'h55, 1'b0, 1'b1));
        send_bit(1'b1, 4);

        sel = 0;
        send_bit(1'b0, 4);
        send_bit(1'b1, 40);
        check("glitch_nodone", 32'(qa.size()), 32'd0);
        send_frame(0, 8'hA3, 1'b0, 1'b1);
        expect_frame("fA3", 0, model(0, 8'hA3, 1'b0, 1'b1));

        send_frame(0, 8'h00, 1'b0, 1'b0);
        expect_frame("break", 0, model(0, 8'h00, 1'b0, 1'b0));
        send_bit(1'b0, 40);
        check("break_hold", 32'(qa.size()), 32'd0);
        send_bit(1'b1, 16);
        send_frame(0, 8'h7E, 1'b0, 1'b1);
        expect_frame("f7E", 0, model(0, 8'h7E, 1'b0, 1'b1));
        send_bit(1'b1, 4);

        send_frame(1, 8'hA5, 1'b1, 1'b1);
        expect_frame("parA5_p1", 1, rec_t'({8'hA5, 1'b0, 1'b1}));
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        expect_frame("parA5_p0", 1, rec_t'({8'hA5, 1'b0, 1'b0}));
        send_bit(1'b1, 4);

        send_frame(0, 8'h01, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        line = 1'b1;
        expect_frame("b2b_01", 0, model(0, 8'h01, 1'b0, 1'b1));
        expect_frame("b2b_FF", 0, model(0, 8'hFF, 1'b0, 1'b1));
        send_bit(1'b1, 4);

        for (int i = 0; i < 30; i++) begin
            s  = $urandom_range(0, 2);
            d  = 8'($urandom);
            pb = 1'($urandom);
            sv = ($urandom_range(0, 5) != 0);
            send_frame(s, d, pb, sv);
            expect_frame($sformatf("rnd%0d", i), s, model(s, d, pb, sv));
            gap = sv ? $urandom_range(0, 2) : 16;
            if (gap > 0) send_bit(1'b1, gap);
        end
        send_bit(1'b1, 4);

        sel = 0;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 8);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_out", {22'd0, data_a, fe_a, pe_a}, 32'd0);
        check("midreset_done", 32'(done_a), 32'd0);
        rst  = 1'b0;
        line = 1'b1;
        send_bit(1'b1, 40);
        check("midreset_nodone", 32'(qa.size()), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        expect_frame("f3C", 0, model(0, 8'h3C, 1'b0, 1'b1));
        send_bit(1'b1, 8);

        check("hold_and_pulse", 32'(viol), 32'd0);
        check("done_count", 32'(done_total), 32'(exp_total));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
